// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch stage and instruction memory.
//
// Signals
//   req    fetch request, one-cycle pulse (fetch stage -> memory)
//   addr   fetch address, stable from req until valid (fetch stage -> memory)
//   rdata  fetched instruction word (memory -> fetch stage)
//   valid  rdata is valid this cycle, at least one cycle after req
//          (memory -> fetch stage)
//
// Modports
//   master  fetch stage side
//   slave   instruction memory side
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Program-counter and instruction-fetch stage sitting directly upstream of
// the control unit. It owns the PC, fetches one instruction word at a time
// over the imem req/valid handshake, and holds the current instruction stable
// until the control unit retires it with i_loadPC.
//
// Sequencing (one instruction at a time):
//   ISSUE : pulse imem.req for one cycle at imem.addr = pc
//   WAIT  : wait for imem.valid, then capture the word into o_instr
//   EXEC  : hold o_instr/o_pc; on i_loadPC load the next pc and go fetch again
//   HALT  : (optional) parked after a retire while i_halt_req is high
//
// Next-pc priority at retire: ret -> i_ret_addr, branch -> pc + sext(instr[9:0]),
// otherwise pc + 1. All arithmetic wraps modulo 2**ADDR_W.
//
// Ports
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   imem          master       instruction-memory read bus (fetch_unit_if)
//   o_instr       out  INSTR_W  current instruction register
//   o_instr_valid out  1        o_instr holds a fetched, unretired instruction
//   o_pc          out  ADDR_W   address of the current instruction
//   o_pc_next_seq out  ADDR_W   pc + 1 (wrapped), return address for JMP
//   i_loadPC      in   1        retire the current instruction
//   i_branch      in   1        taken branch/JMP for the current instruction
//   i_ret         in   1        RET for the current instruction
//   i_ret_addr    in   ADDR_W   popped return address, valid at RET retire
//   i_halt_req    in   1        (FETCH_HALT_EN only) park after next retire
//   o_halted      out  1        (FETCH_HALT_EN only) fetch stage is parked
//
// Configuration macro
//   FETCH_HALT_EN  when defined, adds i_halt_req/o_halted and the HALT state.
//                  When undefined the stage never stops fetching.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc_next_seq,
  input  logic               i_loadPC,
  input  logic               i_branch,
  input  logic               i_ret,
`ifdef FETCH_HALT_EN
  input  logic               i_halt_req,
  output logic               o_halted,
`endif
  input  logic [ADDR_W-1:0]  i_ret_addr
);

  // Branch offsets are always the low 10 instruction bits.
  localparam int OFF_W = 10;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;
`endif

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_instr_valid;

  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_branch_tgt;
  logic [ADDR_W-1:0]   w_next_pc;
  logic                w_capture;
  logic                w_retire;

  // Sign-extend (or truncate) the 10-bit branch offset to the PC width.
  function automatic logic [ADDR_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    logic [ADDR_W-1:0] ext;
    ext = {ADDR_W{1'b0}};
    for (int i = 0; i < ADDR_W; i++) begin
      ext[i] = off[(i < OFF_W) ? i : (OFF_W - 1)];
    end
    return ext;
  endfunction

  // ---------------------------------------------------------------------
  // Next-pc datapath
  // ---------------------------------------------------------------------
  assign w_pc_seq     = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  // Relative to the branch's own address, not pc+1.
  assign w_branch_tgt = r_pc + sext_off(r_instr[OFF_W-1:0]);

  // Select the next pc: ret beats branch beats sequential.
  always_comb begin
    w_next_pc = w_pc_seq;
    if (i_ret) begin
      w_next_pc = i_ret_addr;
    end else if (i_branch) begin
      w_next_pc = w_branch_tgt;
    end else begin
      w_next_pc = w_pc_seq;
    end
  end

  // Capture only in WAIT, so stray valids in other states are dropped.
  assign w_capture = (r_state == ST_WAIT) && imem.valid;
  // branch/ret/loadPC only matter in EXEC.
  assign w_retire  = (r_state == ST_EXEC) && i_loadPC;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ISSUE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.valid) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_EXEC: begin
        if (i_loadPC) begin
`ifdef FETCH_HALT_EN
          if (i_halt_req) begin
            w_next_state = ST_HALT;
          end else begin
            w_next_state = ST_ISSUE;
          end
`else
          w_next_state = ST_ISSUE;
`endif
        end else begin
          w_next_state = ST_EXEC;
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: begin
        if (i_halt_req) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
`endif
      default: begin
        w_next_state = ST_ISSUE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // PC and instruction registers
  // ---------------------------------------------------------------------
  // Capture the fetched word in WAIT; advance the pc when the control unit retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= {INSTR_W{1'b0}};
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr       <= imem.rdata;
      r_instr_valid <= 1'b1;
    end else if (w_retire) begin
      r_pc          <= w_next_pc;
      r_instr_valid <= 1'b0;
    end else begin
      r_pc          <= r_pc;
      r_instr       <= r_instr;
      r_instr_valid <= r_instr_valid;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The state register already sits in ISSUE during reset, so req is masked
  // by rst to keep it low while reset is applied; in the first cycle after
  // reset it goes high straight away.
  assign imem.req  = (r_state == ST_ISSUE) && !rst;
  assign imem.addr = r_pc;

  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_pc_next_seq = w_pc_seq;

`ifdef FETCH_HALT_EN
  assign o_halted = (r_state == ST_HALT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A small instruction-memory model answers
// fetch requests with a programmable latency and can inject a stray valid.
// The control-unit inputs are driven from one linear initial block.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          loadPC = 1'b0;
  logic          branch = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] ret_addr = 10'h000;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next_seq;
`ifdef FETCH_HALT_EN
  logic          halt_req = 1'b0;
  logic          halted;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) imem_bus ();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(10'h000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_pc_next_seq (pc_next_seq),
    .i_loadPC      (loadPC),
    .i_branch      (branch),
    .i_ret         (ret),
`ifdef FETCH_HALT_EN
    .i_halt_req    (halt_req),
    .o_halted      (halted),
`endif
    .i_ret_addr    (ret_addr)
  );

  // Instruction memory model: a request seen in cycle k is answered with
  // valid high during cycle k+lat. A stray valid is sent when spur_req moves.
  logic [IW-1:0] mem [0:1023];
  int            lat = 1;
  int            cnt = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] paddr = 10'h000;
  int            spur_req = 0;
  int            spur_ack = 0;

  always @(negedge clk) begin
    imem_bus.valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
      imem_bus.rdata = 16'h0000;
    end else begin
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_bus.valid = 1'b1;
          imem_bus.rdata = mem[paddr];
          pend = 1'b0;
        end
      end else if (spur_req != spur_ack) begin
        imem_bus.valid = 1'b1;
        imem_bus.rdata = 16'hDEAD;
        spur_ack = spur_req;
      end
      if (imem_bus.req === 1'b1) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_bus.addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire the current instruction with the given control-unit outputs.
  task automatic retire(input logic br, input logic rt, input logic [AW-1:0] ra);
    loadPC = 1'b1; branch = br; ret = rt; ret_addr = ra;
    @(negedge clk);
    loadPC = 1'b0; branch = 1'b0; ret = 1'b0; ret_addr = 10'h000;
  endtask

  // Wait for the next fetch request, check its address, then wait for the
  // captured instruction and check it.
  task automatic fetch(input string tag, input logic [AW-1:0] exp_addr, input logic [IW-1:0] exp_instr);
    int n;
    n = 0;
    while (imem_bus.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, imem_bus.req, 32'd1);
    chk({tag, "_addr"}, imem_bus.addr, exp_addr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (instr_valid !== 1'b1 && n < 20);
    chk({tag, "_vld"}, instr_valid, 32'd1);
    chk({tag, "_pc"}, pc, exp_addr);
    chk({tag, "_instr"}, instr, exp_instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h000] = 16'h1234;
    mem[10'h123] = 16'hC2AB;
    mem[10'h3FE] = 16'h01FF;
    mem[10'h3FF] = 16'h8001;
    mem[10'h010] = 16'h03FC;
    mem[10'h00C] = 16'h5A5A;
    mem[10'h015] = 16'h0777;
    mem[10'h016] = 16'h4321;
    mem[10'h017] = 16'hBEEF;
    mem[10'h005] = 16'h0111;

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_req", imem_bus.req, 32'd0);
    chk("rst_pc", pc, 32'h000);
    chk("rst_instr", instr, 32'h0000);
    chk("rst_vld", instr_valid, 32'd0);

    // First fetch: req at 0 in the first cycle, instr valid two cycles later.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_req", imem_bus.req, 32'd1);
    chk("t1_addr", imem_bus.addr, 32'h000);
    chk("t1_seq", pc_next_seq, 32'h001);
    @(negedge clk);
    chk("t1_wait_vld", instr_valid, 32'd0);
    @(negedge clk);
    chk("t1_vld", instr_valid, 32'd1);
    chk("t1_instr", instr, 32'h1234);
    chk("t1_pc", pc, 32'h000);

    // Five EXEC cycles without loadPC (branch/ret high, stray valid): all held.
    branch = 1'b1; ret = 1'b1; ret_addr = 10'h2AA;
    spur_req++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pc", pc, 32'h000);
      chk("hold_instr", instr, 32'h1234);
      chk("hold_vld", instr_valid, 32'd1);
      chk("hold_req", imem_bus.req, 32'd0);
    end
    branch = 1'b0; ret = 1'b0;

    // ret and branch together: ret wins.
    retire(1'b1, 1'b1, 10'h123);
    fetch("retwin", 10'h123, 16'hC2AB);

    // Sequential wrap 0x3FE -> 0x3FF -> 0x000.
    retire(1'b0, 1'b1, 10'h3FE);
    fetch("seq0", 10'h3FE, 16'h01FF);
    chk("seq0_nseq", pc_next_seq, 32'h3FF);
    retire(1'b0, 1'b0, 10'h000);
    fetch("seq1", 10'h3FF, 16'h8001);
    chk("seq1_nseq", pc_next_seq, 32'h000);
    retire(1'b0, 1'b0, 10'h000);
    fetch("seq2", 10'h000, 16'h1234);

    // Backward branch 0x010 + (-4) = 0x00C.
    retire(1'b0, 1'b1, 10'h010);
    fetch("br_a", 10'h010, 16'h03FC);
    retire(1'b1, 1'b0, 10'h000);
    fetch("br_neg", 10'h00C, 16'h5A5A);

    // Forward branch 0x010 + 5 = 0x015, offset uses only instr[9:0].
    mem[10'h010] = 16'hFC05;
    retire(1'b0, 1'b1, 10'h010);
    fetch("br_b", 10'h010, 16'hFC05);
    retire(1'b1, 1'b0, 10'h000);
    fetch("br_pos", 10'h015, 16'h0777);

    // Four-cycle memory latency: instr holds its old value while waiting.
    lat = 4;
    retire(1'b0, 1'b0, 10'h000);
    chk("lat_req", imem_bus.req, 32'd1);
    chk("lat_addr", imem_bus.addr, 32'h016);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_wait_vld", instr_valid, 32'd0);
      chk("lat_wait_instr", instr, 32'h0777);
    end
    @(negedge clk);
    chk("lat_vld", instr_valid, 32'd1);
    chk("lat_instr", instr, 32'h4321);
    chk("lat_pc", pc, 32'h016);

    // Reset during WAIT aborts the fetch and restarts from 0.
    retire(1'b0, 1'b0, 10'h000);
    chk("abort_addr", imem_bus.addr, 32'h017);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_pc", pc, 32'h000);
    chk("abort_vld", instr_valid, 32'd0);
    chk("abort_instr", instr, 32'h0000);
    chk("abort_req", imem_bus.req, 32'd0);
    @(negedge clk);
    lat = 1;
    @(posedge clk); #1 rst = 1'b0;
    fetch("refetch", 10'h000, 16'h1234);

`ifdef FETCH_HALT_EN
    // Halt at retire of pc=5: pc still advances, no fetch until release.
    retire(1'b0, 1'b1, 10'h005);
    fetch("h_pre", 10'h005, 16'h0111);
    halt_req = 1'b1;
    retire(1'b0, 1'b0, 10'h000);
    chk("h_halted", halted, 32'd1);
    chk("h_pc", pc, 32'h006);
    chk("h_req", imem_bus.req, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("h_hold_req", imem_bus.req, 32'd0);
      chk("h_hold_halted", halted, 32'd1);
    end
    halt_req = 1'b0;
    @(negedge clk);
    chk("h_rel_req", imem_bus.req, 32'd1);
    chk("h_rel_addr", imem_bus.addr, 32'h006);
    chk("h_rel_halted", halted, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
